// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch button front-end: sync, debounce, press detect, mode FSM

// One button path: 2-flop synchroniser, debounce counter, registered rising-edge press pulse.
module stopwatch_btn #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], btn};
    end
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (sync_q[1] == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      level <= ~level;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // One-cycle pulse on the 0->1 transition of the debounced level; release is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_d <= 1'b0;
      press   <= 1'b0;
    end else begin
      level_d <= level;
      press   <= level & ~level_d;
    end
  end

endmodule

// Two button paths feeding a Moore FSM that selects the counter mode and display freeze.
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_lap,
  output logic [1:0] en,
  output logic       lap_freeze,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LAP   = 2'd2,
    PAUSE = 2'd3
  } state_t;

  state_t state;
  state_t state_next;
  logic   start_press;
  logic   lap_press;

  stopwatch_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_start (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_start),
    .press (start_press)
  );

  stopwatch_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_lap (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_lap),
    .press (lap_press)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state; start takes priority when both presses land in the same cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_press) state_next = RUN;
      end
      RUN: begin
        if (start_press)    state_next = PAUSE;
        else if (lap_press) state_next = LAP;
      end
      LAP: begin
        if (start_press)    state_next = PAUSE;
        else if (lap_press) state_next = RUN;
      end
      PAUSE: begin
        if (start_press)    state_next = RUN;
        else if (lap_press) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded purely from the registered state.
  always_comb begin
    en         = 2'b00;
    lap_freeze = 1'b0;
    case (state)
      IDLE:    en = 2'b00;
      RUN:     en = 2'b01;
      LAP: begin
        en         = 2'b10;
        lap_freeze = 1'b1;
      end
      PAUSE:   en = 2'b11;
      default: en = 2'b00;
    endcase
  end

  assign state_o = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed bench for stopwatch_ctrl with DEBOUNCE_CYCLES=4

module tb_stopwatch_ctrl;

  logic       clk;
  logic       reset;
  logic       btn_start;
  logic       btn_lap;
  logic [1:0] en;
  logic       lap_freeze;
  logic [1:0] state_o;

  int n_checks;
  int n_fail;

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_start  (btn_start),
    .btn_lap    (btn_lap),
    .en         (en),
    .lap_freeze (lap_freeze),
    .state_o    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold a button n cycles from a negedge, release, then let the debouncer settle low.
  task automatic press_btn(input bit is_lap, input int n);
    if (is_lap) btn_lap = 1'b1; else btn_start = 1'b1;
    ticks(n);
    if (is_lap) btn_lap = 1'b0; else btn_start = 1'b0;
    ticks(15);
  endtask

  task automatic test_reset;
    reset = 1'b1; btn_start = 1'b0; btn_lap = 1'b0;
    ticks(3);
    n_checks++;
    if (en !== 2'b00) begin n_fail++; $display("FAIL reset_en: got %b want 00", en); end
    n_checks++;
    if (lap_freeze !== 1'b0) begin n_fail++; $display("FAIL reset_freeze: got %b want 0", lap_freeze); end
    n_checks++;
    if (state_o !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state_o); end
    reset = 1'b0;
    ticks(2);
  endtask

  task automatic test_start_latency;
    btn_start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 7) begin
        n_checks++;
        if (en !== 2'b00) begin n_fail++; $display("FAIL latency_edge7: got %b want 00", en); end
      end
      if (k == 8) begin
        n_checks++;
        if (en !== 2'b01) begin n_fail++; $display("FAIL latency_edge8: got %b want 01", en); end
      end
    end
    btn_start = 1'b0;
    ticks(15);
    n_checks++;
    if (en !== 2'b01) begin n_fail++; $display("FAIL held_one_event: got %b want 01", en); end
  endtask

  task automatic test_glitch;
    press_btn(1'b0, 3);
    n_checks++;
    if (en !== 2'b01) begin n_fail++; $display("FAIL glitch_ignored: got %b want 01", en); end
    press_btn(1'b0, 5);
    n_checks++;
    if (en !== 2'b11) begin n_fail++; $display("FAIL press5_pause: got %b want 11", en); end
    n_checks++;
    if (state_o !== 2'd3) begin n_fail++; $display("FAIL press5_state: got %0d want 3", state_o); end
  endtask

  task automatic test_lap;
    press_btn(1'b0, 6);
    n_checks++;
    if (en !== 2'b01) begin n_fail++; $display("FAIL resume_run: got %b want 01", en); end
    press_btn(1'b1, 6);
    n_checks++;
    if (en !== 2'b10 || lap_freeze !== 1'b1) begin
      n_fail++; $display("FAIL lap_enter: got en=%b freeze=%b want en=10 freeze=1", en, lap_freeze);
    end
    press_btn(1'b1, 6);
    n_checks++;
    if (en !== 2'b01 || lap_freeze !== 1'b0) begin
      n_fail++; $display("FAIL lap_exit: got en=%b freeze=%b want en=01 freeze=0", en, lap_freeze);
    end
  endtask

  task automatic test_clear;
    press_btn(1'b0, 6);
    n_checks++;
    if (en !== 2'b11) begin n_fail++; $display("FAIL clear_pause: got %b want 11", en); end
    press_btn(1'b1, 6);
    n_checks++;
    if (en !== 2'b00 || state_o !== 2'd0) begin
      n_fail++; $display("FAIL clear_idle: got en=%b state=%0d want en=00 state=0", en, state_o);
    end
    press_btn(1'b1, 6);
    n_checks++;
    if (en !== 2'b00 || state_o !== 2'd0) begin
      n_fail++; $display("FAIL idle_lap: got en=%b state=%0d want en=00 state=0", en, state_o);
    end
  endtask

  task automatic test_simultaneous;
    bit saw_freeze;
    press_btn(1'b0, 6);
    n_checks++;
    if (en !== 2'b01) begin n_fail++; $display("FAIL simul_pre_run: got %b want 01", en); end
    saw_freeze = 1'b0;
    btn_start = 1'b1; btn_lap = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (lap_freeze) saw_freeze = 1'b1;
    end
    btn_start = 1'b0; btn_lap = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (lap_freeze) saw_freeze = 1'b1;
    end
    n_checks++;
    if (en !== 2'b11) begin n_fail++; $display("FAIL simul_start_wins: got %b want 11", en); end
    n_checks++;
    if (saw_freeze !== 1'b0) begin n_fail++; $display("FAIL simul_no_lap: got freeze seen=%b want 0", saw_freeze); end
  endtask

  task automatic test_reset_mid;
    press_btn(1'b0, 6);
    press_btn(1'b1, 6);
    n_checks++;
    if (en !== 2'b10 || lap_freeze !== 1'b1) begin
      n_fail++; $display("FAIL rmid_lap: got en=%b freeze=%b want en=10 freeze=1", en, lap_freeze);
    end
    btn_start = 1'b1;
    ticks(4);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (en !== 2'b00 || lap_freeze !== 1'b0) begin
      n_fail++; $display("FAIL rmid_async: got en=%b freeze=%b want en=00 freeze=0", en, lap_freeze);
    end
    ticks(3);
    reset = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 7) begin
        n_checks++;
        if (en !== 2'b00) begin n_fail++; $display("FAIL rmid_edge7: got %b want 00", en); end
      end
      if (k == 8) begin
        n_checks++;
        if (en !== 2'b01) begin n_fail++; $display("FAIL rmid_edge8: got %b want 01", en); end
      end
    end
    btn_start = 1'b0;
    ticks(15);
    n_checks++;
    if (en !== 2'b01) begin n_fail++; $display("FAIL rmid_one_event: got %b want 01", en); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1; btn_start = 1'b0; btn_lap = 1'b0;
    test_reset;
    test_start_latency;
    test_glitch;
    test_lap;
    test_clear;
    test_simultaneous;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
